// File: rtl/lsu_if.sv
// lsu_if: execute-stage request/response bundle and data-memory port bundle.
// lsu_if (master = execute stage, slave = LSU):
//   req_valid/req_ready handshake, req_wr, req_size (funct3), req_addr, req_wdata;
//   resp_valid pulse with resp_rdata, resp_misaligned, resp_fault.
// lsu_mem_if (master = LSU, slave = memory block):
//   mem_addr/mem_size/mem_en/mem_wr/mem_wdata out, mem_rdata/mem_exception back.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_fault;
    modport master (
        output req_valid, req_wr, req_size, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_fault
    );
    modport slave (
        input  req_valid, req_wr, req_size, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_fault
    );
endinterface

interface lsu_mem_if #(parameter int ADDR_BITS = 16);
    logic [ADDR_BITS-1:0] mem_addr;
    logic [2:0]           mem_size;
    logic                 mem_en;
    logic                 mem_wr;
    logic [31:0]          mem_wdata;
    logic [31:0]          mem_rdata;
    logic                 mem_exception;
    modport master (
        output mem_addr, mem_size, mem_en, mem_wr, mem_wdata,
        input  mem_rdata, mem_exception
    );
    modport slave (
        input  mem_addr, mem_size, mem_en, mem_wr, mem_wdata,
        output mem_rdata, mem_exception
    );
endinterface

// File: rtl/lsu.sv
// lsu: load/store unit driving the data-memory port for one request at a time.
// Ports:
//   CLK, RST   clock and synchronous active-high reset
//   req        lsu_if.slave: request handshake in, single-cycle response out
//   mem        lsu_mem_if.master: memory block port; addr/size held through read-data cycle
module lsu #(
    parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
    parameter int          ADDR_BITS = 16
) (
    input  logic      CLK,
    input  logic      RST,
    lsu_if.slave      req,
    lsu_mem_if.master mem
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]           state;
    logic                 wr_q;
    logic [2:0]           size_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [31:0]          wdata_q;
    logic [31:0]          rdata_q;
    logic                 mis_q;
    logic                 fault_q;
    logic                 illegal;
    logic                 misaligned;
    logic                 out_of_range;

    // Illegal size codes are reported as alignment exceptions.
    assign illegal      = req.req_size == 3'b011 || req.req_size[2:1] == 2'b11;
    assign misaligned   = illegal
                        || (req.req_size[1:0] == 2'b01 && req.req_addr[0])
                        || (req.req_size == 3'b010 && req.req_addr[1:0] != 2'b00);
    assign out_of_range = req.req_addr[31:ADDR_BITS] != MEM_BASE[31:ADDR_BITS];

    // Ready is masked by RST so it stays low for the whole reset pulse.
    assign req.req_ready       = state == IDLE && !RST;
    assign req.resp_valid      = state == RESP;
    assign req.resp_rdata      = rdata_q;
    assign req.resp_misaligned = mis_q;
    assign req.resp_fault      = fault_q;

    // The latched request drives the memory port directly, so addr/size stay put through HOLD and IDLE.
    assign mem.mem_addr  = addr_q;
    assign mem.mem_size  = size_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_en    = state == ACCESS;
    assign mem.mem_wr    = state == ACCESS && wr_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            wr_q    <= 1'b0;
            size_q  <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            mis_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req.req_valid) begin
                    wr_q    <= req.req_wr;
                    size_q  <= req.req_size;
                    addr_q  <= req.req_addr[ADDR_BITS-1:0];
                    wdata_q <= req.req_wdata;
                    mis_q   <= misaligned;
                    fault_q <= !misaligned && out_of_range;
                    state   <= (misaligned || out_of_range) ? RESP : ACCESS;
                end
                ACCESS: begin
                    fault_q <= mem.mem_exception;
                    state   <= (mem.mem_exception || wr_q) ? RESP : HOLD;
                end
                HOLD: begin
                    rdata_q <= mem.mem_rdata;
                    state   <= RESP;
                end
                default: begin
                    rdata_q <= 32'h0;
                    mis_q   <= 1'b0;
                    fault_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit: the initiator side of the CPU data-memory port. It accepts one load or store at a time from the execute stage and checks alignment and address range. It then drives the SPRAM-backed memory block's port (addr/size/en/wr/data_in) and holds addr and size stable through the read-data cycle. It returns a single-cycle response carrying load data or an exception.

## Interface
- MEM_BASE, 32'h0000_0000: base byte address of data memory; must be 64 KiB aligned.
- ADDR_BITS, 16: memory byte-address width; window is MEM_BASE .. MEM_BASE + 2^ADDR_BITS - 1.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- req_valid  in  1  execute stage presents a request.
- req_ready  out  1  LSU can accept; request is accepted on req_valid & req_ready.
- req_wr  in  1  1 = store, 0 = load.
- req_size  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle response pulse; no backpressure.
- resp_rdata  out  32  load result, already extended by memory; 0 for stores and errors.
- resp_misaligned  out  1  with resp_valid: alignment exception.
- resp_fault  out  1  with resp_valid: out-of-range address or memory-reported exception.
- mem_addr  out  ADDR_BITS  byte address to memory.
- mem_size  out  3  size code to memory (= latched req_size).
- mem_en  out  1  memory enable.
- mem_wr  out  1  memory write.
- mem_wdata  out  32  store data to memory (memory shifts it by addr[1:0]).
- mem_rdata  in  32  memory read data; valid the cycle after an enabled read, while addr/size are held.
- mem_exception  in  1  memory-side alignment exception, combinational on en.

## Operation
- States: IDLE, ACCESS, HOLD, RESP.
- IDLE: req_ready=1. On accept, latch wr, size, addr, and wdata, then check the request:
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Illegal size: 011, 110, 111.
  - Out of range: req_addr[31:ADDR_BITS] != MEM_BASE[31:ADDR_BITS].
  - Misaligned or illegal size → RESP with resp_misaligned=1.
  - Out of range (and aligned) → RESP with resp_fault=1.
  - Misaligned takes priority over fault.
  - Otherwise → ACCESS.
- ACCESS (1 cycle): mem_en=1 and mem_wr=latched wr; mem_addr, mem_size, and mem_wdata come from the latched request.
  - If mem_exception=1: set the fault flag, then → RESP.
  - Else store → RESP; load → HOLD.
- HOLD (1 cycle): mem_en=0 and mem_wr=0; mem_addr and mem_size stay unchanged. Register mem_rdata into resp_rdata, then → RESP.
- RESP (1 cycle): resp_valid=1 with the flags; req_ready=0; then → IDLE. Flags and resp_rdata clear on leaving RESP.
- No memory access (mem_en=0 throughout) is issued for misaligned, illegal, or out-of-range requests.
- mem_addr, mem_size, and mem_wdata hold their last values in IDLE; mem_en=0 and mem_wr=0 outside ACCESS.

## Timing
- Request accepted at edge k. resp_valid is high in cycle:
  - k+3 for a load,
  - k+2 for a store,
  - k+1 for a rejected request.
- Throughput: a new request is accepted in the IDLE cycle after RESP. Load-to-load spacing is 4 cycles.
- req_ready=0 in ACCESS, HOLD, and RESP. req_valid in those states is ignored; the stage must hold its request.
- RST=1 at any edge, including mid-transaction, forces:
  - state IDLE;
  - req_ready=0 during reset, 1 in the first cycle after release;
  - resp_valid, resp_misaligned, resp_fault = 0 and resp_rdata=0;
  - mem_en, mem_wr = 0 and mem_addr, mem_size, mem_wdata = 0.
- A write in flight at reset may already have committed in memory; no rollback.

## Test plan
- Store W 0xDEADBEEF to 0x100, then load W from 0x100:
  - store: mem_en & mem_wr for 1 cycle, resp_valid at k+2;
  - load: resp_rdata=0xDEADBEEF at k+3, flags 0.
- Store B 0x80 to 0x103, then LB and LBU from 0x103 → 0xFFFFFF80 and 0x00000080.
  - During each load's HOLD cycle: mem_addr=0x0103, mem_size held, mem_en=0.
- LW from 0x102 and LH from 0x101 → resp_misaligned=1 at k+1, mem_en never asserted. The same for req_size=011.
- LW from 0x0001_0000 (MEM_BASE=0) → resp_fault=1 at k+1, mem_en=0.
- Back-to-back: req_valid held high with two loads:
  - second accepted exactly 4 cycles after the first;
  - req_ready low for 3 cycles in between.
- RST pulsed in HOLD of a load → no resp_valid, outputs zero; the next request after release completes normally.
